// File: rtl/mux_arb_pkg.sv
// Shared constants for the 4-requester round-robin mux arbiter:
// FSM state encodings, requester count, select width and the reset value of "last".
package mux_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  // last resets to 3 so that requester 0 is searched first
  localparam logic [SEL_W-1:0] LAST_RST = 2'd3;

  function automatic logic [N_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set req bit searching last+1, last+2,
// last+3, last (modulo 4).
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] win,
  output logic             found
);

  always_comb begin
    logic [SEL_W-1:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = last + SEL_W'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux with registered one-hot grant/select.
// Optional per-owner hold limit: define MUX4_ARB_HOLD_LIMIT_EN.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       gnt_chg
);

  if (HOLD_MAX < 1) begin : g_hold_max_chk
    $error("HOLD_MAX must be at least 1");
  end

  logic [0:0]       state_q;
  logic [SEL_W-1:0] last_q;
  logic [N_REQ-1:0] pick_req;
  logic [SEL_W-1:0] win;
  logic             found;
  logic             keep;

  // Masking the current owner makes "found" mean "someone else is waiting";
  // when the owner has dropped req the mask changes nothing.
  assign pick_req = req & ~gnt;

  rr_pick4 u_pick (
    .req   (pick_req),
    .last  (last_q),
    .win   (win),
    .found (found)
  );

`ifdef MUX4_ARB_HOLD_LIMIT_EN
  localparam int unsigned CW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);

  logic [CW-1:0] hold_cnt;
  logic          at_limit;

  assign at_limit = (hold_cnt == CW'(HOLD_MAX));
  assign keep     = (state_q == ST_OWN) && req[sel] && !(at_limit && found);

  // Counts owned cycles of the current grant; restarts at the limit when nobody waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (keep) begin
      hold_cnt <= at_limit ? CW'(1) : hold_cnt + CW'(1);
    end else if (found) begin
      hold_cnt <= CW'(1);
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  assign keep = (state_q == ST_OWN) && req[sel];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_RST;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      gnt_chg <= 1'b0;
    end else if (keep) begin
      gnt_chg <= 1'b0;
    end else if (found) begin
      state_q <= ST_OWN;
      last_q  <= win;
      sel     <= win;
      gnt     <= sel_to_onehot(win);
      busy    <= 1'b1;
      gnt_chg <= 1'b1;
    end else begin
      state_q <= ST_IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      gnt_chg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: behavioural round-robin model,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_mux4_rr_arbiter;

  localparam int HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       gnt_chg;

  int checks   = 0;
  int failures = 0;

  mux4_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .gnt_chg (gnt_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: owner index (-1 = nobody), last owner, owned-cycle count.
  int         m_owner;
  int         m_last;
  int         m_cnt;
  int         m_sel;
  bit         m_chg;
  int         wait_grants [4];

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_cnt   = 0;
    m_sel   = 0;
    m_chg   = 0;
    for (int i = 0; i < 4; i++) wait_grants[i] = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] others;
    bit         force_sw;
    int         w;
    others   = r;
    force_sw = 0;
    if (m_owner >= 0) others[m_owner] = 1'b0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
    if (m_owner >= 0 && r[m_owner] && m_cnt == HOLD && others != 0) force_sw = 1;
`endif
    if (m_owner >= 0 && r[m_owner] && !force_sw) begin
      m_chg = 0;
      m_cnt = (m_cnt == HOLD) ? 1 : m_cnt + 1;
    end else if (others != 0) begin
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && others[(m_last + k) % 4]) w = (m_last + k) % 4;
      m_owner = w;
      m_last  = w;
      m_sel   = w;
      m_chg   = 1;
      m_cnt   = 1;
    end else begin
      m_owner = -1;
      m_chg   = 0;
      m_cnt   = 0;
    end
  endtask

  always @(negedge rst_n) model_reset();

  // Single compare process: model update on each rising edge, DUT check 1 time unit later.
  always @(posedge clk) begin
    logic [3:0] r;
    logic [3:0] e_gnt;
    int         new_owner;
    r = req;
    if (!rst_n) model_reset();
    else        model_step(r);
    e_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    #1;
    checks++;
    if (gnt !== e_gnt || sel !== 2'(m_sel) || busy !== (m_owner >= 0) || gnt_chg !== m_chg) begin
      failures++;
      $display("FAIL model t=%0t req=%b got gnt=%b sel=%0d busy=%b chg=%b want gnt=%b sel=%0d busy=%b chg=%b",
               $time, r, gnt, sel, busy, gnt_chg, e_gnt, m_sel, (m_owner >= 0), m_chg);
    end
    checks++;
    if ($countones(gnt) > 1 || busy !== (gnt != 4'b0000) ||
        (busy && gnt !== (4'b0001 << sel))) begin
      failures++;
      $display("FAIL onehot t=%0t got gnt=%b sel=%0d busy=%b", $time, gnt, sel, busy);
    end
    // Starvation: count grants handed to others while a requester keeps req high.
    new_owner = -1;
    for (int i = 0; i < 4; i++) if (gnt[i]) new_owner = i;
    for (int i = 0; i < 4; i++) begin
      if (!rst_n || !r[i] || new_owner == i) wait_grants[i] = 0;
      else if (gnt_chg) wait_grants[i]++;
    end
    if (rst_n) begin
      checks++;
      if (wait_grants[0] > 3 || wait_grants[1] > 3 || wait_grants[2] > 3 || wait_grants[3] > 3) begin
        failures++;
        $display("FAIL starve t=%0t got waits=%0d,%0d,%0d,%0d want <=3", $time,
                 wait_grants[0], wait_grants[1], wait_grants[2], wait_grants[3]);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rnd;
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    chk("async_reset_gnt", {4'b0, gnt}, 8'b0);
    do_reset();
    chk("reset_gnt", {4'b0, gnt}, 8'b0);
    chk("reset_sel_busy_chg", {4'b0, sel, busy, gnt_chg}, 8'b0);

    // All request: requester 0 first, then 1 once 0 drops
    cyc(4'b1111);
    chk("all_req_gnt", {4'b0, gnt}, 8'b0000_0001);
    chk("all_req_sel_chg", {5'b0, sel, gnt_chg}, {5'b0, 2'd0, 1'b1});
    cyc(4'b1110);
    chk("drop0_gnt", {4'b0, gnt}, 8'b0000_0010);
    chk("drop0_sel_chg", {5'b0, sel, gnt_chg}, {5'b0, 2'd1, 1'b1});

    // Owner 3 then wrap to 0 with no idle gap, then idle
    cyc(4'b1000);
    chk("own3_gnt", {4'b0, gnt}, 8'b0000_1000);
    cyc(4'b0001);
    chk("wrap_gnt", {4'b0, gnt}, 8'b0000_0001);
    chk("wrap_busy_chg", {6'b0, busy, gnt_chg}, 8'b0000_0011);
    cyc(4'b0000);
    chk("idle_gnt", {4'b0, gnt}, 8'b0);
    chk("idle_busy_sel", {5'b0, busy, sel}, 8'b0);

    // Owner 2 holds for 20 cycles; pulse only in the first
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0100);
      chk("hold2_gnt", {4'b0, gnt}, 8'b0000_0100);
      chk("hold2_chg", {7'b0, gnt_chg}, (i == 0) ? 8'd1 : 8'd0);
    end

    // Asynchronous reset mid-grant, then requesters 0 and 2
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", {4'b0, gnt}, 8'b0);
    chk("midrst_sel_busy_chg", {4'b0, sel, busy, gnt_chg}, 8'b0);
    @(negedge clk);
    req = 4'b0101;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("post_rst_gnt", {4'b0, gnt}, 8'b0000_0001);
    chk("post_rst_chg", {7'b0, gnt_chg}, 8'd1);

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    do_reset();
    for (int i = 0; i < 3 * HOLD; i++) begin
      cyc(4'b0011);
      chk("limit_alt_gnt", {4'b0, gnt}, ((i / HOLD) % 2 == 0) ? 8'b0000_0001 : 8'b0000_0010);
    end
`endif

    // Randomized traffic: each request bit toggles with probability 1/4 per cycle
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      rnd = $urandom;
      @(negedge clk);
      req = req ^ (rnd[3:0] & rnd[7:4]);
    end
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
